// File: rtl/pmbus_pkg.sv
// pmbus_pkg: shared types and constants for the PMBus register arbiter.
//   t_arb_states            arbiter FSM states
//   PMBUS_CMD_WRITE_PROTECT PMBus WRITE_PROTECT command code / register address
//   PMBUS_TIMEOUT_FILL      read data returned for a timed-out access (all-ones)
//   REQ_SMB / REQ_SEQ       requester index in the one-hot grant vectors
package pmbus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } t_arb_states;

  localparam logic [7:0] PMBUS_CMD_WRITE_PROTECT = 8'h10;

  // Wide enough for MAX_BYTES up to 16; users slice the low MAX_BYTES*8 bits.
  localparam int                      PMBUS_MAX_DW       = 128;
  localparam logic [PMBUS_MAX_DW-1:0] PMBUS_TIMEOUT_FILL = '1;

  localparam int REQ_SMB = 0;
  localparam int REQ_SEQ = 1;

endpackage

// File: rtl/pmbus_rr_arb2.sv
// pmbus_rr_arb2: two-way round-robin grant with a last-grant pointer.
//   gclk, grst_n  clock, async active-low reset
//   req_i[1:0]    request vector (bit0 SMB, bit1 SEQ)
//   upd_i         strobe: record upd_gnt_i as the last grant
//   upd_gnt_i     one-hot grant that just completed
//   gnt_o[1:0]    one-hot combinational grant for the current requests
// After reset the pointer says SEQ was last, so SMB wins the first tie.
module pmbus_rr_arb2 (
  input  logic       gclk,
  input  logic       grst_n,
  input  logic [1:0] req_i,
  input  logic       upd_i,
  input  logic [1:0] upd_gnt_i,
  output logic [1:0] gnt_o
);

  logic last_seq_q, last_seq_d;

  always_comb begin
    last_seq_d = last_seq_q;
    if (upd_i) last_seq_d = upd_gnt_i[1];
  end

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) last_seq_q <= 1'b1;
    else         last_seq_q <= last_seq_d;
  end

  always_comb begin
    gnt_o = 2'b00;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = last_seq_q ? 2'b01 : 2'b10;
      default: gnt_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/pmbus_reg_arbiter.sv
// pmbus_reg_arbiter: shares one Avalon-MM register target between the PMBus
// slave bridge (SMB_*) and the power-sequencer master (SEQ_*).
//   CLOCK, RESET_N          clock, async active-low reset
//   SMB_*                   PMBus bridge localbus (command code = address)
//   SEQ_*                   sequencer local master
//   AV_*                    downstream Avalon-MM target
//   ERR_CLEAR               clears sticky error flags (a same-cycle set wins)
//   ERR_TIMEOUT/ERR_PROTECT sticky error flags
// Build option: define PMBUS_WRITE_PROTECT_EN to enable the WRITE_PROTECT
// (command 0x10) register that blocks PMBus writes while bit 7 is set.
// Every output is a register, so async reset returns all of them at once.
module pmbus_reg_arbiter
  import pmbus_pkg::*;
#(
  parameter int MAX_BYTES    = 2,
  parameter int TIMEOUT_CLKS = 1024
) (
  input  logic                   CLOCK,
  input  logic                   RESET_N,
  input  logic [7:0]             SMB_COMMAND,
  input  logic [MAX_BYTES-1:0]   SMB_BYTEEN,
  input  logic                   SMB_READ,
  input  logic                   SMB_WRITE,
  input  logic [MAX_BYTES*8-1:0] SMB_WRITEDATA,
  output logic                   SMB_WAITREQUEST,
  output logic [MAX_BYTES*8-1:0] SMB_READDATA,
  input  logic [7:0]             SEQ_ADDRESS,
  input  logic [MAX_BYTES-1:0]   SEQ_BYTEEN,
  input  logic                   SEQ_READ,
  input  logic                   SEQ_WRITE,
  input  logic [MAX_BYTES*8-1:0] SEQ_WRITEDATA,
  output logic                   SEQ_WAITREQUEST,
  output logic [MAX_BYTES*8-1:0] SEQ_READDATA,
  output logic [7:0]             AV_ADDRESS,
  output logic [MAX_BYTES-1:0]   AV_BYTEEN,
  output logic                   AV_READ,
  output logic                   AV_WRITE,
  output logic [MAX_BYTES*8-1:0] AV_WRITEDATA,
  input  logic                   AV_WAITREQUEST,
  input  logic [MAX_BYTES*8-1:0] AV_READDATA,
  input  logic                   ERR_CLEAR,
  output logic                   ERR_TIMEOUT,
  output logic                   ERR_PROTECT
);

  localparam int          DW      = MAX_BYTES * 8;
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CLKS - 1);

  t_arb_states             state_q, state_d;
  logic [1:0]              gnt_q, gnt_d;
  logic [15:0]             cnt_q, cnt_d;
  logic [7:0]              addr_q, addr_d;
  logic [MAX_BYTES-1:0]    be_q, be_d;
  logic [DW-1:0]           wdata_q, wdata_d;
  logic                    rd_q, rd_d, wr_q, wr_d;
  logic [1:0][DW-1:0]      rdata_q, rdata_d;   // [REQ_SMB], [REQ_SEQ]
  logic [1:0]              wait_q, wait_d;     // per-requester waitrequest
  logic                    err_to_q, err_to_d;

  logic [1:0]              req, arb_gnt;
  logic                    upd;
  logic                    sel_seq;
  logic                    req_wr;
  logic                    smb_blocked;

  // Read+write together counts as a write.
  assign req     = {SEQ_READ | SEQ_WRITE, SMB_READ | SMB_WRITE};
  assign sel_seq = arb_gnt[REQ_SEQ];
  assign req_wr  = sel_seq ? SEQ_WRITE : SMB_WRITE;

  pmbus_rr_arb2 u_arb (
    .gclk      (CLOCK),
    .grst_n    (RESET_N),
    .req_i     (req),
    .upd_i     (upd),
    .upd_gnt_i (gnt_q),
    .gnt_o     (arb_gnt)
  );

`ifdef PMBUS_WRITE_PROTECT_EN
  logic [7:0] wp_q;
  logic       wp_we;
  logic       err_prot_q;

  // The WRITE_PROTECT command itself is always let through so it can be undone.
  assign smb_blocked = wp_q[7] && SMB_WRITE && (SMB_COMMAND != PMBUS_CMD_WRITE_PROTECT);
  assign wp_we       = (state_q == ST_IDLE) && arb_gnt[REQ_SMB] && SMB_WRITE &&
                       (SMB_COMMAND == PMBUS_CMD_WRITE_PROTECT) && SMB_BYTEEN[0];

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      wp_q       <= '0;
      err_prot_q <= 1'b0;
    end else begin
      if (wp_we) wp_q <= SMB_WRITEDATA[7:0];
      if ((state_q == ST_IDLE) && arb_gnt[REQ_SMB] && smb_blocked) err_prot_q <= 1'b1;
      else if (ERR_CLEAR)                                          err_prot_q <= 1'b0;
    end
  end

  assign ERR_PROTECT = err_prot_q;
`else
  assign smb_blocked = 1'b0;
  assign ERR_PROTECT = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    be_d     = be_q;
    wdata_d  = wdata_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    rdata_d  = rdata_q;
    wait_d   = 2'b11;
    err_to_d = ERR_CLEAR ? 1'b0 : err_to_q;
    upd      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          gnt_d = arb_gnt;
          if (arb_gnt[REQ_SMB] && smb_blocked) begin
            // Blocked write: complete to the bridge without touching the target.
            wait_d[REQ_SMB] = 1'b0;
            state_d         = ST_RESP;
          end else begin
            addr_d  = sel_seq ? SEQ_ADDRESS   : SMB_COMMAND;
            be_d    = sel_seq ? SEQ_BYTEEN    : SMB_BYTEEN;
            wdata_d = sel_seq ? SEQ_WRITEDATA : SMB_WRITEDATA;
            wr_d    = req_wr;
            rd_d    = !req_wr;
            cnt_d   = '0;
            state_d = ST_ISSUE;
          end
        end
      end

      ST_ISSUE: begin
        cnt_d = cnt_q + 16'd1;
        if (!AV_WAITREQUEST) begin
          rdata_d[gnt_q[REQ_SEQ]] = AV_READDATA;
          rd_d                    = 1'b0;
          wr_d                    = 1'b0;
          wait_d                  = ~gnt_q;
          state_d                 = ST_RESP;
        end else if (cnt_q == TO_LAST) begin
          rdata_d[gnt_q[REQ_SEQ]] = PMBUS_TIMEOUT_FILL[DW-1:0];
          rd_d                    = 1'b0;
          wr_d                    = 1'b0;
          wait_d                  = ~gnt_q;
          err_to_d                = 1'b1;
          state_d                 = ST_RESP;
        end
      end

      ST_RESP: begin
        upd     = 1'b1;
        cnt_d   = '0;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= ST_IDLE;
      gnt_q    <= '0;
      cnt_q    <= '0;
      addr_q   <= '0;
      be_q     <= '0;
      wdata_q  <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      rdata_q  <= '0;
      wait_q   <= 2'b11;
      err_to_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      be_q     <= be_d;
      wdata_q  <= wdata_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      rdata_q  <= rdata_d;
      wait_q   <= wait_d;
      err_to_q <= err_to_d;
    end
  end

  assign SMB_WAITREQUEST = wait_q[REQ_SMB];
  assign SEQ_WAITREQUEST = wait_q[REQ_SEQ];
  assign SMB_READDATA    = rdata_q[REQ_SMB];
  assign SEQ_READDATA    = rdata_q[REQ_SEQ];
  assign AV_ADDRESS      = addr_q;
  assign AV_BYTEEN       = be_q;
  assign AV_WRITEDATA    = wdata_q;
  assign AV_READ         = rd_q;
  assign AV_WRITE        = wr_q;
  assign ERR_TIMEOUT     = err_to_q;

endmodule

// File: tb/tb_pmbus_reg_arbiter.sv
// tb_pmbus_reg_arbiter: directed bench for pmbus_reg_arbiter (TIMEOUT_CLKS=8).
module tb_pmbus_reg_arbiter;

  localparam int MB = 2;
  localparam int DW = MB * 8;

  logic          CLOCK = 1'b0;
  logic          RESET_N;
  logic [7:0]    SMB_COMMAND;
  logic [MB-1:0] SMB_BYTEEN;
  logic          SMB_READ, SMB_WRITE;
  logic [DW-1:0] SMB_WRITEDATA;
  logic          SMB_WAITREQUEST;
  logic [DW-1:0] SMB_READDATA;
  logic [7:0]    SEQ_ADDRESS;
  logic [MB-1:0] SEQ_BYTEEN;
  logic          SEQ_READ, SEQ_WRITE;
  logic [DW-1:0] SEQ_WRITEDATA;
  logic          SEQ_WAITREQUEST;
  logic [DW-1:0] SEQ_READDATA;
  logic [7:0]    AV_ADDRESS;
  logic [MB-1:0] AV_BYTEEN;
  logic          AV_READ, AV_WRITE;
  logic [DW-1:0] AV_WRITEDATA;
  logic          AV_WAITREQUEST;
  logic [DW-1:0] AV_READDATA;
  logic          ERR_CLEAR;
  logic          ERR_TIMEOUT, ERR_PROTECT;

  int n_run  = 0;
  int n_fail = 0;

  logic [DW-1:0] smb_exp, seq_exp;

  pmbus_reg_arbiter #(.MAX_BYTES(MB), .TIMEOUT_CLKS(8)) dut (
    .CLOCK(CLOCK), .RESET_N(RESET_N),
    .SMB_COMMAND(SMB_COMMAND), .SMB_BYTEEN(SMB_BYTEEN), .SMB_READ(SMB_READ),
    .SMB_WRITE(SMB_WRITE), .SMB_WRITEDATA(SMB_WRITEDATA),
    .SMB_WAITREQUEST(SMB_WAITREQUEST), .SMB_READDATA(SMB_READDATA),
    .SEQ_ADDRESS(SEQ_ADDRESS), .SEQ_BYTEEN(SEQ_BYTEEN), .SEQ_READ(SEQ_READ),
    .SEQ_WRITE(SEQ_WRITE), .SEQ_WRITEDATA(SEQ_WRITEDATA),
    .SEQ_WAITREQUEST(SEQ_WAITREQUEST), .SEQ_READDATA(SEQ_READDATA),
    .AV_ADDRESS(AV_ADDRESS), .AV_BYTEEN(AV_BYTEEN), .AV_READ(AV_READ),
    .AV_WRITE(AV_WRITE), .AV_WRITEDATA(AV_WRITEDATA),
    .AV_WAITREQUEST(AV_WAITREQUEST), .AV_READDATA(AV_READDATA),
    .ERR_CLEAR(ERR_CLEAR), .ERR_TIMEOUT(ERR_TIMEOUT), .ERR_PROTECT(ERR_PROTECT)
  );

  always #5 CLOCK = ~CLOCK;

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One SMB/SEQ read grant with the target accepting at once: issue, resp, idle.
  task automatic grant_rd(input bit is_seq, input logic [7:0] addr, input logic [DW-1:0] d);
    tick();
    chk("gnt_av_read", AV_READ, 1);
    chk("gnt_addr", AV_ADDRESS, addr);
    chk("gnt_waits_issue", {SEQ_WAITREQUEST, SMB_WAITREQUEST}, 2'b11);
    AV_READDATA = d;
    tick();
    if (is_seq) seq_exp = d; else smb_exp = d;
    chk("gnt_av_read_drop", AV_READ, 0);
    chk("gnt_waits_resp", {SEQ_WAITREQUEST, SMB_WAITREQUEST}, is_seq ? 2'b01 : 2'b10);
    chk("gnt_smb_rdata", SMB_READDATA, smb_exp);
    chk("gnt_seq_rdata", SEQ_READDATA, seq_exp);
    tick();
    chk("gnt_waits_idle", {SEQ_WAITREQUEST, SMB_WAITREQUEST}, 2'b11);
  endtask

  initial begin
    RESET_N = 1'b0;
    SMB_COMMAND = '0; SMB_BYTEEN = '0; SMB_READ = 0; SMB_WRITE = 0; SMB_WRITEDATA = '0;
    SEQ_ADDRESS = '0; SEQ_BYTEEN = '0; SEQ_READ = 0; SEQ_WRITE = 0; SEQ_WRITEDATA = '0;
    AV_WAITREQUEST = 0; AV_READDATA = '0; ERR_CLEAR = 0;
    smb_exp = '0; seq_exp = '0;

    // Reset values
    #12;
    chk("rst_waits", {SEQ_WAITREQUEST, SMB_WAITREQUEST}, 2'b11);
    chk("rst_strobes", {AV_READ, AV_WRITE}, 2'b00);
    chk("rst_av_regs", {AV_ADDRESS, AV_BYTEEN, AV_WRITEDATA}, '0);
    chk("rst_rdata", {SMB_READDATA, SEQ_READDATA}, '0);
    chk("rst_err", {ERR_TIMEOUT, ERR_PROTECT}, 2'b00);
    @(negedge CLOCK); RESET_N = 1'b1;

    // SMB read 0x21, immediate accept
    tick();
    SMB_COMMAND = 8'h21; SMB_READ = 1; AV_READDATA = 16'hBEEF;
    tick();
    chk("rd_av_read", AV_READ, 1);
    chk("rd_addr", AV_ADDRESS, 8'h21);
    chk("rd_smb_wait_issue", SMB_WAITREQUEST, 1);
    tick();
    chk("rd_av_read_1cyc", AV_READ, 0);
    chk("rd_smb_wait_done", SMB_WAITREQUEST, 0);
    chk("rd_smb_rdata", SMB_READDATA, 16'hBEEF);
    chk("rd_seq_wait", SEQ_WAITREQUEST, 1);
    SMB_READ = 0;
    tick();
    chk("rd_smb_wait_back", SMB_WAITREQUEST, 1);
    chk("rd_seq_rdata_hold", SEQ_READDATA, 16'h0000);

    // Round-robin from reset: SMB, SEQ, SMB, SEQ
    @(negedge CLOCK); RESET_N = 1'b0;
    @(negedge CLOCK); RESET_N = 1'b1;
    smb_exp = '0; seq_exp = '0;
    SMB_COMMAND = 8'h01; SEQ_ADDRESS = 8'h02; SMB_READ = 1; SEQ_READ = 1;
    grant_rd(1'b0, 8'h01, 16'h1111);
    grant_rd(1'b1, 8'h02, 16'h2222);
    grant_rd(1'b0, 8'h01, 16'h3333);
    grant_rd(1'b1, 8'h02, 16'h4444);
    SMB_READ = 0; SEQ_READ = 0;

    // SEQ write 0x40 with a 5-cycle downstream stall
    SEQ_ADDRESS = 8'h40; SEQ_WRITEDATA = 16'h1234; SEQ_BYTEEN = 2'b11;
    SEQ_WRITE = 1; AV_WAITREQUEST = 1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      chk("wr_av_write_held", AV_WRITE, 1);
      chk("wr_av_read_low", AV_READ, 0);
      chk("wr_addr_data", {AV_ADDRESS, AV_WRITEDATA, AV_BYTEEN}, {8'h40, 16'h1234, 2'b11});
      chk("wr_seq_wait_stall", SEQ_WAITREQUEST, 1);
      if (i == 6) AV_WAITREQUEST = 0;
    end
    tick();
    chk("wr_av_write_drop", AV_WRITE, 0);
    chk("wr_seq_wait_done", SEQ_WAITREQUEST, 0);
    chk("wr_smb_wait", SMB_WAITREQUEST, 1);
    SEQ_WRITE = 0;
    tick();
    chk("wr_seq_wait_1cyc", SEQ_WAITREQUEST, 1);

    // Timeout: target never accepts an SMB read
    SMB_COMMAND = 8'h33; SMB_READ = 1; AV_WAITREQUEST = 1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk("to_av_read_held", AV_READ, 1);
      chk("to_smb_wait", SMB_WAITREQUEST, 1);
    end
    tick();
    chk("to_av_read_drop", AV_READ, 0);
    chk("to_smb_wait_done", SMB_WAITREQUEST, 0);
    chk("to_smb_rdata", SMB_READDATA, 16'hFFFF);
    chk("to_err", ERR_TIMEOUT, 1);
    SMB_READ = 0; AV_WAITREQUEST = 0;
    tick();
    chk("to_err_sticky", ERR_TIMEOUT, 1);
    ERR_CLEAR = 1;
    tick();
    ERR_CLEAR = 0;
    chk("to_err_cleared", ERR_TIMEOUT, 0);

    // WRITE_PROTECT command 0x10 then an SMB write to 0x21
    SMB_COMMAND = 8'h10; SMB_WRITEDATA = 16'h0080; SMB_BYTEEN = 2'b01; SMB_WRITE = 1;
    tick();
    chk("wp_fwd_write", AV_WRITE, 1);
    chk("wp_fwd_addr", {AV_ADDRESS, AV_WRITEDATA}, {8'h10, 16'h0080});
    tick();
    chk("wp_fwd_done", SMB_WAITREQUEST, 0);
    SMB_WRITE = 0;
    tick();
    SMB_COMMAND = 8'h21; SMB_WRITEDATA = 16'h5555; SMB_BYTEEN = 2'b11; SMB_WRITE = 1;
    tick();
`ifdef PMBUS_WRITE_PROTECT_EN
    chk("wp_blk_no_write", AV_WRITE, 0);
    chk("wp_blk_done", SMB_WAITREQUEST, 0);
    chk("wp_blk_err", ERR_PROTECT, 1);
    chk("wp_blk_addr_kept", AV_ADDRESS, 8'h10);
    SMB_WRITE = 0;
    tick();
    chk("wp_blk_idle_write", AV_WRITE, 0);
    chk("wp_blk_wait_back", SMB_WAITREQUEST, 1);
`else
    chk("wp_off_write", AV_WRITE, 1);
    chk("wp_off_addr", AV_ADDRESS, 8'h21);
    chk("wp_off_err", ERR_PROTECT, 0);
    tick();
    chk("wp_off_done", SMB_WAITREQUEST, 0);
    SMB_WRITE = 0;
    tick();
`endif
    SEQ_ADDRESS = 8'h21; SEQ_WRITEDATA = 16'h0A0A; SEQ_WRITE = 1;
    tick();
    chk("wp_seq_write", AV_WRITE, 1);
    chk("wp_seq_addr", {AV_ADDRESS, AV_WRITEDATA}, {8'h21, 16'h0A0A});
    tick();
    chk("wp_seq_done", SEQ_WAITREQUEST, 0);
    SEQ_WRITE = 0;
    tick();

    // Reset mid-issue; pointer returns to favouring SMB
    SMB_COMMAND = 8'h05; SMB_READ = 1; AV_READDATA = 16'h0505;
    tick(); tick();
    chk("ri_smb_done", SMB_WAITREQUEST, 0);
    SMB_READ = 0;
    tick();
    SEQ_ADDRESS = 8'h06; SEQ_READ = 1; AV_WAITREQUEST = 1;
    tick();
    chk("ri_seq_issue", {AV_READ, AV_ADDRESS}, {1'b1, 8'h06});
    tick(); tick();
    #2; RESET_N = 1'b0; #1;
    chk("ri_strobes", {AV_READ, AV_WRITE}, 2'b00);
    chk("ri_waits", {SEQ_WAITREQUEST, SMB_WAITREQUEST}, 2'b11);
    chk("ri_rdata", {SMB_READDATA, SEQ_READDATA}, '0);
    @(negedge CLOCK);
    chk("ri_no_completion", SEQ_WAITREQUEST, 1);
    RESET_N = 1'b1;
    SMB_COMMAND = 8'h07; SMB_READ = 1; AV_WAITREQUEST = 0; AV_READDATA = 16'h7777;
    tick();
    chk("ri_smb_first", {AV_READ, AV_ADDRESS}, {1'b1, 8'h07});
    tick();
    chk("ri_smb_resp", {SEQ_WAITREQUEST, SMB_WAITREQUEST}, 2'b10);
    SMB_READ = 0;
    tick(); tick();
    chk("ri_seq_next", {AV_READ, AV_ADDRESS}, {1'b1, 8'h06});
    tick();
    chk("ri_seq_resp", {SEQ_WAITREQUEST, SEQ_READDATA}, {1'b0, 16'h7777});
    SEQ_READ = 0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
